// File: rtl/prio_encoder_q.sv
// prio_encoder_q: sticky request collector feeding a one-entry grant register.
// Define PRIO_ROUND_ROBIN_EN for round-robin selection; default is fixed lowest-index priority.
module prio_encoder_q #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         lost
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_pending;
  logic [W-1:0] r_idx;
  logic         r_lost;
  logic [W-1:0] w_sel;
  logic         w_load;
  logic [N-1:0] w_clr;

  // Load decisions look only at registered pending, so a new req is visible one edge later.
  assign w_load = (|r_pending) && ((r_state == S_EMPTY) || out_ready);
  assign w_clr  = w_load ? (N'(1) << w_sel) : '0;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;
  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;
  logic [W:0]   w_sum;

  // Rotate so the search origin lands on bit 0, then map the hit back.
  assign w_rot = N'({r_pending, r_pending} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = N-1; i >= 0; i--)
      if (w_rot[i]) w_off = W'(i);
  end

  assign w_sum = {1'b0, w_off} + {1'b0, r_ptr};
  assign w_sel = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : W'(w_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= '0;
    else if (w_load) r_ptr <= (w_sel == W'(N-1)) ? '0 : w_sel + 1'b1;
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = N-1; i >= 0; i--)
      if (r_pending[i]) w_sel = W'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_lost    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | req;
      r_lost    <= |(req & r_pending & ~w_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_idx <= '0;
    else if (w_load) r_idx <= w_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_load) w_state_nxt = S_FULL;
      S_FULL:  if (out_ready) w_state_nxt = w_load ? S_FULL : S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_FULL);
  end

  assign out_idx = r_idx;
  assign pending = r_pending;
  assign lost    = r_lost;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Scoreboard bench for prio_encoder_q: expected grant indices are queued at stimulus time
// and popped by a monitor on every accepted handshake.
module tb_prio_encoder_q;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         lost;

  int vectors = 0;
  int miscompares = 0;
  int sb[$];
  int exp_idx;

  always #5 clk = ~clk;

  prio_encoder_q #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .pending(pending), .lost(lost)
  );

  // Handshake inputs change 1 time unit after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL grant: got idx %0d, expected no grant", out_idx);
      end else begin
        exp_idx = sb.pop_front();
        if (out_idx !== W'(exp_idx)) begin
          miscompares++;
          $display("FAIL grant: got idx %0d, expected %0d", out_idx, exp_idx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    req = '0; out_ready = 1'b1;
    for (int c = 0; c < 40 && (sb.size() != 0 || out_valid || pending != '0); c++) tick();
  endtask

  task automatic test_reset();
    req = 8'h01; out_ready = 1'b0;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || out_idx !== 3'd0 || lost !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b pending=%h idx=%0d lost=%b, expected 0/00/0/0",
               out_valid, pending, out_idx, lost);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || pending !== 8'h01) begin
      miscompares++;
      $display("FAIL first_edge: valid=%b pending=%h, expected 0/01", out_valid, pending);
    end
    req = '0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL second_edge: valid=%b idx=%0d, expected 1/0", out_valid, out_idx);
    end
    sb.push_back(0);
    drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drain: left=%0d valid=%b, expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_onehot();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req = N'(1) << i;
      sb.push_back(i);
      tick();
      if (i > 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== W'(i-1)) begin
          miscompares++;
          $display("FAIL onehot_latency: valid=%b idx=%0d, expected 1/%0d", out_valid, out_idx, i-1);
        end
      end
    end
    drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL onehot_drain: left=%0d valid=%b, expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_multi();
    logic [N-1:0] pexp [4];
    pexp = '{8'hA4, 8'hA0, 8'h80, 8'h00};
    out_ready = 1'b1;
    req = 8'hA4;
    sb.push_back(2); sb.push_back(5); sb.push_back(7);
    tick();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (pending !== pexp[k]) begin
        miscompares++;
        $display("FAIL multi_pending[%0d]: got %h, expected %h", k, pending, pexp[k]);
      end
      tick();
    end
    drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_drain: left=%0d valid=%b, expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req = 8'h03;
    tick();
    req = '0;
    sb.push_back(0); sb.push_back(1);
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending !== 8'h02) begin
        miscompares++;
        $display("FAIL hold[%0d]: valid=%b idx=%0d pending=%h, expected 1/0/02",
                 k, out_valid, out_idx, pending);
      end
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL release: valid=%b idx=%0d, expected 1/1", out_valid, out_idx);
    end
    drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: left=%0d valid=%b, expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_lost();
    out_ready = 1'b0;
    req = 8'h09;
    tick();
    req = '0;
    tick();
    vectors++;
    if (lost !== 1'b0 || pending !== 8'h08) begin
      miscompares++;
      $display("FAIL lost_pre: lost=%b pending=%h, expected 0/08", lost, pending);
    end
    req = 8'h08;
    tick();
    vectors++;
    if (lost !== 1'b1 || pending !== 8'h08) begin
      miscompares++;
      $display("FAIL lost_pulse: lost=%b pending=%h, expected 1/08", lost, pending);
    end
    req = '0;
    tick();
    vectors++;
    if (lost !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_clear: lost=%b, expected 0", lost);
    end
    sb.push_back(0); sb.push_back(3);
    drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_drain: left=%0d valid=%b, expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    req = 8'h01;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(0);
      tick();
      vectors++;
      if (lost !== 1'b0 || pending !== 8'h01) begin
        miscompares++;
        $display("FAIL b2b[%0d]: lost=%b pending=%h, expected 0/01", k, lost, pending);
      end
    end
    drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0 || pending !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_drain: left=%0d valid=%b pending=%h, expected 0/0/00",
               sb.size(), out_valid, pending);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    req = 8'hF0;
    tick();
    req = '0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || pending !== 8'hE0) begin
      miscompares++;
      $display("FAIL mid_pre: valid=%b idx=%0d pending=%h, expected 1/4/E0", out_valid, out_idx, pending);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || out_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b pending=%h idx=%0d, expected 0/00/0", out_valid, pending, out_idx);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_post[%0d]: valid=%b, expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_rr();
`ifdef PRIO_ROUND_ROBIN_EN
    for (int k = 0; k < 7; k++) sb.push_back((k % 2 == 0) ? 0 : 7);
`else
    for (int k = 0; k < 6; k++) sb.push_back(0);
    sb.push_back(7);
`endif
    out_ready = 1'b1;
    req = 8'h81;
    for (int k = 0; k < 6; k++) tick();
    drain();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0 || pending !== 8'h00) begin
      miscompares++;
      $display("FAIL rr_drain: left=%0d valid=%b pending=%h, expected 0/0/00",
               sb.size(), out_valid, pending);
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_multi();
    test_backpressure();
    test_lost();
    test_back_to_back();
    test_reset_mid();
    test_rr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
